// File: rtl/ls_pkg.sv
// rtl/ls_pkg.sv - shared types and constants for the LS-series logic models
package ls_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t NIBBLE_MAX = 4'hF;

    function automatic logic nibble_is_max(input nibble_t value);
        return value == NIBBLE_MAX;
    endfunction

endpackage

// File: rtl/ls161_bit.sv
// rtl/ls161_bit.sv - one LS161 counter stage: async-reset flop with load/toggle/hold mux
// Optional macro LS161_CLR_EN adds the active-low asynchronous clear input clr_n.
module ls161_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
`ifdef LS161_CLR_EN
    input  logic clr_n,
`endif
    input  logic load_n,
    input  logic toggle,
    input  logic d,
    output logic q
);

    logic next_q;

    // Ternary selection keeps an unknown load_n/toggle visible as X on q.
    assign next_q = load_n ? (toggle ? ~q : q) : d;

`ifdef LS161_CLR_EN
    // rst outranks clr_n so the board reset value wins when both are asserted.
    always_ff @(posedge clk or posedge rst or negedge clr_n) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (!clr_n) begin
            q <= 1'b0;
        end else begin
            q <= next_q;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            q <= next_q;
        end
    end
`endif

endmodule

// File: rtl/ls161_counter.sv
// rtl/ls161_counter.sv - 4-bit synchronous binary counter with parallel load and ripple carry
// Optional macro LS161_CLR_EN adds the _CLR pin (active-low asynchronous clear to 4'h0).
module ls161_counter
    import ls_pkg::*;
#(
    parameter nibble_t RESET_VAL = 4'h0
) (
    input  logic _CLK,
    input  logic _RESET,
`ifdef LS161_CLR_EN
    input  logic _CLR,
`endif
    input  logic _LOAD,
    input  logic _ENP,
    input  logic _ENT,
    input  logic _A,
    input  logic _B,
    input  logic _C,
    input  logic _D,
    output logic _QA,
    output logic _QB,
    output logic _QC,
    output logic _QD,
    output logic _RCO
);

    nibble_t q;
    nibble_t data;
    nibble_t toggle;

    assign data = {_D, _C, _B, _A};

    // Each stage toggles only when every lower stage is already high.
    assign toggle[0] = _ENP & _ENT;

    genvar i;
    generate
        for (i = 1; i < 4; i++) begin : g_chain
            assign toggle[i] = toggle[i-1] & q[i-1];
        end

        for (i = 0; i < 4; i++) begin : g_bit
            ls161_bit #(
                .RST_VAL (RESET_VAL[i])
            ) u_bit (
                .clk    (_CLK),
                .rst    (_RESET),
`ifdef LS161_CLR_EN
                .clr_n  (_CLR),
`endif
                .load_n (_LOAD),
                .toggle (toggle[i]),
                .d      (data[i]),
                .q      (q[i])
            );
        end
    endgenerate

    // Gated by _ENT but not _ENP, so cascaded stages get look-ahead carry.
    assign _RCO = _ENT & nibble_is_max(q);

    assign _QA = q[0];
    assign _QB = q[1];
    assign _QC = q[2];
    assign _QD = q[3];

endmodule
